// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard emulator: turns key events into Set-2 byte sequences and
// drives them as 11-bit device-to-host frames on ps2_clk/ps2_data.
// Optional build macro PS2_EXT_EN: key_ext=1 prepends an E0 byte.
module ps2_keyboard_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_ext,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] byte_cnt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef PS2_EXT_EN
  localparam int unsigned QD = 3;
`else
  localparam int unsigned QD = 2;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;

  state_t                state_q, state_d;
  logic [QD-1:0][7:0]    q_q, q_d;
  logic [1:0]            q_cnt_q, q_cnt_d;
  logic [10:0]           frame_q, frame_d;
  logic [3:0]            bit_q, bit_d;
  logic                  phase_q, phase_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  ps2_clk_d, ps2_data_d;
  logic [7:0]            byte_cnt_d;

`ifndef PS2_EXT_EN
  logic unused_key_ext;
  assign unused_key_ext = key_ext;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      q_cnt_q   <= 2'd0;
      frame_q   <= '1;
      bit_q     <= 4'd0;
      phase_q   <= 1'b0;
      div_q     <= '0;
      gap_q     <= '0;
      ps2_clk   <= 1'b1;
      ps2_data  <= 1'b1;
      byte_cnt  <= 8'd0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      q_cnt_q   <= q_cnt_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      gap_q     <= gap_d;
      ps2_clk   <= ps2_clk_d;
      ps2_data  <= ps2_data_d;
      byte_cnt  <= byte_cnt_d;
      key_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    q_cnt_d    = q_cnt_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    div_d      = div_q;
    gap_d      = gap_q;
    ps2_clk_d  = ps2_clk;
    ps2_data_d = ps2_data;
    byte_cnt_d = byte_cnt;

    unique case (state_q)
      IDLE: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (key_valid) begin
          // Queue head is element 0; bytes leave in index order
          q_d = '0;
`ifdef PS2_EXT_EN
          if (key_ext && key_release) begin
            q_d[0] = 8'hE0; q_d[1] = 8'hF0; q_d[2] = key_code; q_cnt_d = 2'd3;
          end else if (key_ext) begin
            q_d[0] = 8'hE0; q_d[1] = key_code; q_cnt_d = 2'd2;
          end else
`endif
          if (key_release) begin
            q_d[0] = 8'hF0; q_d[1] = key_code; q_cnt_d = 2'd2;
          end else begin
            q_d[0] = key_code; q_cnt_d = 2'd1;
          end
          state_d = LOAD;
        end
      end

      LOAD: begin
        frame_d    = {1'b1, ~^q_q[0], q_q[0], 1'b0};
        q_d        = (QD*8)'(q_q >> 8);
        q_cnt_d    = q_cnt_q - 2'd1;
        bit_d      = 4'd0;
        phase_d    = 1'b0;
        div_d      = '0;
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b0;
        state_d    = FRAME;
      end

      FRAME: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d   = 1'b1;
            ps2_clk_d = 1'b0;
          end else if (bit_q == 4'd10) begin
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
            byte_cnt_d = byte_cnt + 8'd1;
            gap_d      = '0;
            state_d    = GAP;
          end else begin
            // Data moves only at the start of a high phase
            bit_d      = bit_q + 4'd1;
            phase_d    = 1'b0;
            frame_d    = frame_q >> 1;
            ps2_clk_d  = 1'b1;
            ps2_data_d = frame_q[1];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = (q_cnt_q != 2'd0) ? LOAD : IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: decodes frames off the PS/2 lines and compares
// them with a byte-queue model of the key-event encoding.
module tb_ps2_keyboard_tx;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int          FRAME_CYC  = 1 + 22 * CLK_DIV + GAP_CYCLES;
`ifdef PS2_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] key_code = 8'h00;
  logic       key_release = 1'b0;
  logic       key_ext = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] byte_cnt;

  ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_release(key_release), .key_ext(key_ext),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] frame_log[$];
  int          exp_cnt = 0;
  int          mon_nbits = 0;
  logic [10:0] mon_bits = '0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one event becomes [E0] [F0] code
  task automatic enqueue(input logic [7:0] code, input logic rel, input logic ext, output int n);
    n = 0;
    if (EXT_EN && ext) begin exp_q.push_back(8'hE0); n++; end
    if (rel) begin exp_q.push_back(8'hF0); n++; end
    exp_q.push_back(code); n++;
    exp_cnt = (exp_cnt + n) % 256;
  endtask

  task automatic check_frame(input logic [10:0] f);
    frame_log.push_back(f);
    check("start_bit", 32'(f[0]), 0);
    check("stop_bit", 32'(f[10]), 1);
    check("odd_parity", 32'(^f[9:1]), 1);
    check("frame_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) check("frame_byte", 32'(f[8:1]), 32'(exp_q.pop_front()));
  endtask

  // Line monitor: host-side sampling on ps2_clk falling edges
  always @(negedge clk) begin
    if (!rst) begin
      mon_nbits = 0;
      prev_clk  = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (ps2_data !== prev_data) check("data_moves_with_clk_high", 32'(ps2_clk), 1);
      if (prev_clk && !ps2_clk) begin
        mon_bits = {ps2_data, mon_bits[10:1]};
        mon_nbits++;
        if (mon_nbits == 11) begin
          check_frame(mon_bits);
          mon_nbits = 0;
        end
      end
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic send_event(input logic [7:0] code, input logic rel, input logic ext, input bit inject);
    int n;
    int cycles;
    int waitc;
    waitc = 0;
    while (!key_ready && waitc < 1000) begin @(negedge clk); waitc++; end
    check("ready_before_event", 32'(key_ready), 1);
    enqueue(code, rel, ext, n);
    key_code = code; key_release = rel; key_ext = ext; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 8'($urandom); key_release = 1'($urandom); key_ext = 1'($urandom);
    cycles = 0;
    while (busy && cycles < 1000) begin
      if (inject && cycles == 10) begin
        key_valid = 1'b1; key_code = 8'h32; key_release = 1'b0;
        check("ready_low_mid_event", 32'(key_ready), 0);
      end
      if (inject && cycles == 11) key_valid = 1'b0;
      @(negedge clk);
      cycles++;
    end
    key_valid = 1'b0;
    check("event_duration", cycles, n * FRAME_CYC);
    check("byte_cnt", 32'(byte_cnt), exp_cnt);
    check("all_bytes_sent", exp_q.size(), 0);
    check("ready_after_event", 32'(key_ready), 1);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_ps2_clk", 32'(ps2_clk), 1);
    check("rst_ps2_data", 32'(ps2_data), 1);
    check("rst_byte_cnt", 32'(byte_cnt), 0);
    check("rst_key_ready", 32'(key_ready), 1);
    check("rst_busy", 32'(busy), 0);
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int waitc;
    int t;
    int last_t;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ps2_clk", 32'(ps2_clk), 1);
    check("reset_ps2_data", 32'(ps2_data), 1);
    check("reset_key_ready", 32'(key_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_byte_cnt", 32'(byte_cnt), 0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Make 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1
    send_event(8'h1C, 1'b0, 1'b0, 1'b0);
    check("make_1c_bits", 32'(frame_log[$]), 32'h438);

    // Release 0x1C: F0 then 1C
    send_event(8'h1C, 1'b1, 1'b0, 1'b0);
    check("release_f0_bits", 32'(frame_log[$-1]), 32'h7E0);
    check("release_1c_bits", 32'(frame_log[$]), 32'h438);

    // Event offered mid-transfer is dropped
    send_event(8'h1C, 1'b1, 1'b0, 1'b1);

    // Reset during data bit 4 of a frame
    key_code = 8'h1C; key_release = 1'b0; key_ext = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    waitc = 0;
    while (!(mon_nbits == 5 && ps2_clk) && waitc < 500) begin @(negedge clk); waitc++; end
    check("reached_bit4", 32'(mon_nbits), 5);
    pulse_reset();
    send_event(8'h5A, 1'b0, 1'b0, 1'b0);
    check("clean_after_reset", 32'(frame_log[$]), {21'd0, 1'b1, ~^8'h5A, 8'h5A, 1'b0});

    // Extended release 0x75
    send_event(8'h75, 1'b1, 1'b1, 1'b0);
    check("ext_75_bits", 32'(frame_log[$]), 32'h4EA);
    check("ext_f0_bits", 32'(frame_log[$-1]), 32'h7E0);
`ifdef PS2_EXT_EN
    check("ext_e0_bits", 32'(frame_log[$-2]), 32'h5C0);
`endif

    // Randomized events
    for (int i = 0; i < 24; i++)
      send_event(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // 256 back-to-back makes with key_valid held high
    pulse_reset();
    key_release = 1'b0; key_ext = 1'b0; key_valid = 1'b1;
    t = 0; last_t = 0;
    for (int i = 0; i < 256; i++) begin
      waitc = 0;
      while (!key_ready && waitc < 200) begin @(negedge clk); t++; waitc++; end
      if (i > 0) check("b2b_period", t - last_t, FRAME_CYC + 1);
      last_t = t;
      key_code = 8'($urandom);
      enqueue(key_code, 1'b0, 1'b0, n);
      @(negedge clk);
      t++;
    end
    key_valid = 1'b0;
    waitc = 0;
    while (busy && waitc < 200) begin @(negedge clk); waitc++; end
    check("b2b_done", 32'(busy), 0);
    check("byte_cnt_wrap", 32'(byte_cnt), 0);
    check("b2b_all_sent", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
